// File: rtl/vga_pkg.sv
// Shared VGA scan-out definitions: 640x480@60 timing set, pixel address and
// RGB332 types used by both the GPU controller and the display path.
package vga_pkg;

    localparam int   VGA_H_ACTIVE = 640;
    localparam int   VGA_H_FP     = 16;
    localparam int   VGA_H_SYNC   = 96;
    localparam int   VGA_H_BP     = 48;
    localparam int   VGA_V_ACTIVE = 480;
    localparam int   VGA_V_FP     = 10;
    localparam int   VGA_V_SYNC   = 2;
    localparam int   VGA_V_BP     = 33;
    localparam logic VGA_SYNC_POL = 1'b0;

    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
    localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;
    localparam int VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;
    localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;

    typedef logic [19:0] pix_addr_t;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
        logic origin;
    } scan_flags_t;

    // Same {y, x} packing the GPU controller writes VRAM with.
    function automatic pix_addr_t pix_addr(input logic [9:0] y, input logic [9:0] x);
        return {y, x};
    endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// VRAM read port between the scan-out stage (master) and VRAM (slave).
interface vga_scanout_if;
    import vga_pkg::*;

    logic      vram_rd_en;
    pix_addr_t vram_rd_addr;
    logic [7:0] vram_rd_data;

    modport master (output vram_rd_en, output vram_rd_addr, input vram_rd_data);
    modport slave  (input vram_rd_en, input vram_rd_addr, output vram_rd_data);

endinterface

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters and the stage-0 region flags derived
// from them. Everything advances only on pix_ce.
module vga_timing import vga_pkg::*; #(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_ce,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       active,
    output logic       hs_raw,
    output logic       vs_raw,
    output logic       origin
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    // Line and frame wrap share the same tick, so there is no dead cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_ce) begin
            if (h_cnt == 10'(H_TOTAL - 1)) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == 10'(V_TOTAL - 1)) ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    always_comb begin
        active = (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
        hs_raw = (h_cnt >= 10'(HS_START)) && (h_cnt < 10'(HS_END));
        vs_raw = (v_cnt >= 10'(VS_START)) && (v_cnt < 10'(VS_END));
        origin = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    end

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out: raster timing, one VRAM read per visible pixel, and a
// 2-tick pipeline keeping RGB, blank and syncs phase-aligned at the pins.
module vga_scanout import vga_pkg::*; #(
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic SYNC_POL = VGA_SYNC_POL
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pix_ce,
    vga_scanout_if.master vram,
    output logic [2:0]    vga_r,
    output logic [2:0]    vga_g,
    output logic [1:0]    vga_b,
    output logic          hsync,
    output logic          vsync,
    output logic          blank,
    output logic          frame_start
);

    logic [9:0]  h_cnt, v_cnt;
    logic        active, hs_raw, vs_raw, origin;
    scan_flags_t s0, s1;
    logic        rd_pend;
    rgb332_t     pix_q, pix_src, rgb_q;

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk    (clk),
        .rst_n  (rst_n),
        .pix_ce (pix_ce),
        .h_cnt  (h_cnt),
        .v_cnt  (v_cnt),
        .active (active),
        .hs_raw (hs_raw),
        .vs_raw (vs_raw),
        .origin (origin)
    );

    assign s0 = '{active: active, hs: hs_raw, vs: vs_raw, origin: origin};

    // Counters sit at (0,0) during reset, so the strobe is gated by rst_n
    // to keep VRAM quiet until the raster is actually running.
    assign vram.vram_rd_en   = pix_ce & s0.active & rst_n;
    assign vram.vram_rd_addr = s0.active ? pix_addr(v_cnt, h_cnt) : '0;

    // Read data is only guaranteed the clk after the strobe; capture it
    // there so slow pix_ce rates tolerate VRAM changing its bus afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend <= 1'b0;
            pix_q   <= '0;
        end else begin
            rd_pend <= vram.vram_rd_en;
            if (rd_pend) pix_q <= rgb332_t'(vram.vram_rd_data);
        end
    end

    assign pix_src = rd_pend ? rgb332_t'(vram.vram_rd_data) : pix_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1          <= '0;
            rgb_q       <= '0;
            blank       <= 1'b1;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_ce & s1.origin;
            if (pix_ce) begin
                s1    <= s0;
                rgb_q <= s1.active ? pix_src : '0;
                blank <= ~s1.active;
                hsync <= s1.hs ? SYNC_POL : ~SYNC_POL;
                vsync <= s1.vs ? SYNC_POL : ~SYNC_POL;
            end
        end
    end

    assign vga_r = rgb_q.r;
    assign vga_g = rgb_q.g;
    assign vga_b = rgb_q.b;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a full-size instance for line-level checks and a
// shrunken-raster instance (25x11, active-high syncs) for frame-level checks.
module tb_vga_scanout;
    import vga_pkg::*;

    logic clk    = 1'b0;
    logic rst_n  = 1'b1;
    logic pix_ce = 1'b0;
    always #5 clk = ~clk;

    vga_scanout_if a_if();
    vga_scanout_if b_if();

    logic [2:0] a_r, a_g, b_r, b_g;
    logic [1:0] a_b, b_b;
    logic a_hs, a_vs, a_blank, a_fs, b_hs, b_vs, b_blank, b_fs;
    logic [11:0] a_out, b_out;
    assign a_out = {a_blank, a_hs, a_vs, a_fs, a_r, a_g, a_b};
    assign b_out = {b_blank, b_hs, b_vs, b_fs, b_r, b_g, b_b};

    vga_scanout u_a (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .vram(a_if),
        .vga_r(a_r), .vga_g(a_g), .vga_b(a_b),
        .hsync(a_hs), .vsync(a_vs), .blank(a_blank), .frame_start(a_fs)
    );

    vga_scanout #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b1)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .vram(b_if),
        .vga_r(b_r), .vga_g(b_g), .vga_b(b_b),
        .hsync(b_hs), .vsync(b_vs), .blank(b_blank), .frame_start(b_fs)
    );

    int tests_run = 0;
    int tests_failed = 0;
    int vmode_a = 0;   // 0: addr-derived data, 1: constant 0xFF, 2: scramble when idle
    int vmode_b = 0;

    always @(posedge clk) begin
        if (vmode_a == 1)              a_if.vram_rd_data <= 8'hFF;
        else if (!rst_n)               a_if.vram_rd_data <= 8'h00;
        else if (a_if.vram_rd_en)      a_if.vram_rd_data <= a_if.vram_rd_addr[7:0];
        else if (vmode_a == 2)         a_if.vram_rd_data <= 8'($urandom);
    end

    always @(posedge clk) begin
        if (vmode_b == 1)              b_if.vram_rd_data <= 8'hFF;
        else if (!rst_n)               b_if.vram_rd_data <= 8'h00;
        else if (b_if.vram_rd_en)      b_if.vram_rd_data <= {b_if.vram_rd_addr[12:10], b_if.vram_rd_addr[4:0]};
        else if (vmode_b == 2)         b_if.vram_rd_data <= 8'($urandom);
    end

    // Expected pins while pixel p is displayed (p<0: nothing displayed yet).
    function automatic logic [11:0] exp_a(input int p, input int mode);
        int h, v;
        logic act, hs, vs, fs;
        logic [7:0] d;
        if (p < 0) return 12'hE00;
        h = p % 800;
        v = (p / 800) % 525;
        act = (h < 640) && (v < 480);
        hs = (h >= 656) && (h < 752);
        vs = (v >= 490) && (v < 492);
        fs = (p % 420000) == 0;
        d = (mode == 1) ? 8'hFF : 8'(h);
        return {!act, !hs, !vs, fs, act ? d : 8'h00};
    endfunction

    function automatic logic [20:0] exp_a_rd(input int t);
        int h, v;
        h = t % 800;
        v = (t / 800) % 525;
        if ((h < 640) && (v < 480)) return {1'b1, 10'(v), 10'(h)};
        return 21'h0;
    endfunction

    function automatic logic [11:0] exp_b(input int p, input int mode);
        int h, v;
        logic [9:0] hv, vv;
        logic act, hs, vs, fs;
        logic [7:0] d;
        if (p < 0) return 12'h800;
        h = p % 25;
        v = (p / 25) % 11;
        hv = 10'(h);
        vv = 10'(v);
        act = (h < 16) && (v < 6);
        hs = (h >= 18) && (h < 22);
        vs = (v >= 7) && (v < 9);
        fs = (p % 275) == 0;
        d = (mode == 1) ? 8'hFF : {vv[2:0], hv[4:0]};
        return {!act, hs, vs, fs, act ? d : 8'h00};
    endfunction

    function automatic logic [20:0] exp_b_rd(input int t);
        int h, v;
        h = t % 25;
        v = (t / 25) % 11;
        if ((h < 16) && (v < 6)) return {1'b1, 10'(v), 10'(h)};
        return 21'h0;
    endfunction

    logic      a_en_pre, b_en_pre;
    pix_addr_t a_addr_pre, b_addr_pre;

    // One clk: drive pix_ce, sample the combinational read port, then step
    // past the edge so registered outputs can be sampled.
    task automatic tick(input logic ce);
        pix_ce = ce;
        #1;
        a_en_pre   = a_if.vram_rd_en;
        a_addr_pre = a_if.vram_rd_addr;
        b_en_pre   = b_if.vram_rd_en;
        b_addr_pre = b_if.vram_rd_addr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n  = 1'b0;
        pix_ce = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        #1;
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pix_ce = (i % 2) == 1;
            #1;
            tests_run++;
            if ({a_out, a_if.vram_rd_en} !== {12'hE00, 1'b0}) begin
                tests_failed++;
                $display("FAIL reset_a cyc %0d: got %h want %h", i, {a_out, a_if.vram_rd_en}, {12'hE00, 1'b0});
            end
            tests_run++;
            if ({b_out, b_if.vram_rd_en} !== {12'h800, 1'b0}) begin
                tests_failed++;
                $display("FAIL reset_b cyc %0d: got %h want %h", i, {b_out, b_if.vram_rd_en}, {12'h800, 1'b0});
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_first_line;
        int low_cnt, first_low;
        pix_addr_t addr639;
        logic [7:0] rgb641;
        logic blank642;
        vmode_a = 0;
        do_reset();
        low_cnt = 0;
        first_low = -1;
        for (int t = 0; t < 806; t++) begin
            tick(1'b1);
            tests_run++;
            if ({a_en_pre, a_addr_pre} !== exp_a_rd(t)) begin
                tests_failed++;
                $display("FAIL line_rd t=%0d: got %h want %h", t, {a_en_pre, a_addr_pre}, exp_a_rd(t));
            end
            tests_run++;
            if (a_out !== exp_a(t - 1, 0)) begin
                tests_failed++;
                $display("FAIL line_pins t=%0d: got %h want %h", t, a_out, exp_a(t - 1, 0));
            end
            if (t == 639) addr639 = a_addr_pre;
            if (t == 640) rgb641 = {a_r, a_g, a_b};
            if (t == 641) blank642 = a_blank;
            if (a_hs == 1'b0) begin
                low_cnt++;
                if (first_low < 0) first_low = t + 1;
            end
        end
        tests_run++;
        if (addr639 !== 20'h0027F) begin
            tests_failed++;
            $display("FAIL addr_tick639: got %h want 0027f", addr639);
        end
        tests_run++;
        if (rgb641 !== 8'h7F) begin
            tests_failed++;
            $display("FAIL rgb_tick641: got %h want 7f", rgb641);
        end
        tests_run++;
        if (blank642 !== 1'b1) begin
            tests_failed++;
            $display("FAIL blank_tick642: got %b want 1", blank642);
        end
        tests_run++;
        if (low_cnt != 96 || first_low != 658) begin
            tests_failed++;
            $display("FAIL hsync_window: got len %0d start %0d want 96 658", low_cnt, first_low);
        end
    endtask

    task automatic test_frame_b;
        int fs0, fs1, vs_cnt, vs_first;
        vmode_b = 0;
        do_reset();
        fs0 = -1; fs1 = -1; vs_cnt = 0; vs_first = -1;
        for (int t = 0; t < 556; t++) begin
            tick(1'b1);
            tests_run++;
            if ({b_en_pre, b_addr_pre} !== exp_b_rd(t)) begin
                tests_failed++;
                $display("FAIL frame_rd t=%0d: got %h want %h", t, {b_en_pre, b_addr_pre}, exp_b_rd(t));
            end
            tests_run++;
            if (b_out !== exp_b(t - 1, 0)) begin
                tests_failed++;
                $display("FAIL frame_pins t=%0d: got %h want %h", t, b_out, exp_b(t - 1, 0));
            end
            if (b_fs) begin
                if (fs0 < 0) fs0 = t;
                else if (fs1 < 0) fs1 = t;
            end
            if (b_vs && t < 276) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = t + 1;
            end
        end
        tests_run++;
        if (fs0 != 1 || fs1 - fs0 != 275) begin
            tests_failed++;
            $display("FAIL frame_period: got first %0d gap %0d want 1 275", fs0, fs1 - fs0);
        end
        tests_run++;
        if (vs_cnt != 50 || vs_first != 177) begin
            tests_failed++;
            $display("FAIL vsync_window: got len %0d start %0d want 50 177", vs_cnt, vs_first);
        end
    endtask

    task automatic test_blank_leak;
        vmode_a = 1;
        vmode_b = 1;
        do_reset();
        for (int t = 0; t < 806; t++) begin
            tick(1'b1);
            tests_run++;
            if ({a_en_pre, a_addr_pre} !== exp_a_rd(t) || a_out !== exp_a(t - 1, 1)) begin
                tests_failed++;
                $display("FAIL leak_a t=%0d: got %h/%h want %h/%h", t, {a_en_pre, a_addr_pre}, a_out, exp_a_rd(t), exp_a(t - 1, 1));
            end
            tests_run++;
            if ({b_en_pre, b_addr_pre} !== exp_b_rd(t) || b_out !== exp_b(t - 1, 1)) begin
                tests_failed++;
                $display("FAIL leak_b t=%0d: got %h/%h want %h/%h", t, {b_en_pre, b_addr_pre}, b_out, exp_b_rd(t), exp_b(t - 1, 1));
            end
        end
        vmode_a = 0;
        vmode_b = 0;
    endtask

    task automatic test_ce_quarter;
        int n, fs0, fs1;
        logic [11:0] exp;
        vmode_b = 2;
        do_reset();
        n = 0; fs0 = -1; fs1 = -1;
        exp = exp_b(-1, 2);
        for (int c = 0; c < 2240; c++) begin
            if ((c % 4) == 0) begin
                tick(1'b1);
                tests_run++;
                if ({b_en_pre, b_addr_pre} !== exp_b_rd(n)) begin
                    tests_failed++;
                    $display("FAIL q_rd c=%0d: got %h want %h", c, {b_en_pre, b_addr_pre}, exp_b_rd(n));
                end
                exp = exp_b(n - 1, 2);
                n++;
            end else begin
                tick(1'b0);
                tests_run++;
                if (b_en_pre !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL q_idle_rd c=%0d: got %b want 0", c, b_en_pre);
                end
                exp[8] = 1'b0;
            end
            tests_run++;
            if (b_out !== exp) begin
                tests_failed++;
                $display("FAIL q_pins c=%0d: got %h want %h", c, b_out, exp);
            end
            if (b_fs) begin
                if (fs0 < 0) fs0 = c;
                else if (fs1 < 0) fs1 = c;
            end
        end
        tests_run++;
        if (fs1 - fs0 != 1100) begin
            tests_failed++;
            $display("FAIL q_frame_period: got %0d want 1100", fs1 - fs0);
        end
        vmode_b = 0;
    endtask

    task automatic test_mid_reset;
        vmode_a = 0;
        vmode_b = 0;
        do_reset();
        for (int t = 0; t < 85; t++) tick(1'b1);
        pix_ce = 1'b1;
        rst_n  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests_run++;
            if ({a_out, a_if.vram_rd_en} !== {12'hE00, 1'b0} || {b_out, b_if.vram_rd_en} !== {12'h800, 1'b0}) begin
                tests_failed++;
                $display("FAIL midrst_hold i=%0d: got %h %h want %h %h", i, {a_out, a_if.vram_rd_en},
                         {b_out, b_if.vram_rd_en}, {12'hE00, 1'b0}, {12'h800, 1'b0});
            end
            if (i < 3) @(posedge clk);
        end
        rst_n = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick(1'b1);
            tests_run++;
            if ({a_en_pre, a_addr_pre} !== exp_a_rd(t) || {b_en_pre, b_addr_pre} !== exp_b_rd(t)) begin
                tests_failed++;
                $display("FAIL midrst_rd t=%0d: got %h %h want %h %h", t, {a_en_pre, a_addr_pre},
                         {b_en_pre, b_addr_pre}, exp_a_rd(t), exp_b_rd(t));
            end
            tests_run++;
            if (a_fs !== (t == 1) || b_fs !== (t == 1)) begin
                tests_failed++;
                $display("FAIL midrst_fs t=%0d: got %b %b want %b", t, a_fs, b_fs, t == 1);
            end
            tests_run++;
            if (a_out !== exp_a(t - 1, 0) || b_out !== exp_b(t - 1, 0)) begin
                tests_failed++;
                $display("FAIL midrst_pins t=%0d: got %h %h want %h %h", t, a_out, b_out, exp_a(t - 1, 0), exp_b(t - 1, 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_line();
        test_frame_b();
        test_blank_leak();
        test_ce_quarter();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Display scan-out stage downstream of the GPU controller and its VRAM. Generates 640x480@60 VGA timing from a pixel clock-enable, and issues one VRAM read per active pixel using the same `{y[9:0], x[9:0]}` 20-bit pixel address the GPU controller writes with. The returned RGB332 byte is driven to the DAC pins, with hsync/vsync delayed to stay aligned with pixel data.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `SYNC_POL`, 1'b0, asserted level of hsync/vsync (0 = active-low)
- `clk`  in  1  system clock
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `pix_ce`  in  1  pixel tick; all timing advances only on clk edges with pix_ce=1
- `vram_rd_en`  out  1  VRAM read strobe, one clk wide
- `vram_rd_addr`  out  20  `{v_cnt[9:0], h_cnt[9:0]}`
- `vram_rd_data`  in  8  RGB332 byte; valid 1 clk after `vram_rd_en`, held until next read
- `vga_r`  out  3  red, `data[7:5]`
- `vga_g`  out  3  green, `data[4:2]`
- `vga_b`  out  2  blue, `data[1:0]`
- `hsync`  out  1  horizontal sync
- `vsync`  out  1  vertical sync
- `blank`  out  1  1 outside the active area, aligned with RGB
- `frame_start`  out  1  one-clk pulse when pixel (0,0) appears on the outputs

## Operation
- Counters:
  - `h_cnt` counts 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
  - `v_cnt` counts 0..V_TOTAL-1 (525). It increments when `h_cnt` wraps and itself wraps to 0 after 524.
  - Both are 10 bits wide; no count exceeds 1023.
- Stage 0 (counters):
  - `active` = `h_cnt < H_ACTIVE && v_cnt < V_ACTIVE`.
  - `hs_raw` = `h_cnt` in [656, 752).
  - `vs_raw` = `v_cnt` in [490, 492).
  - `vram_rd_en` = `pix_ce & active`, combinational.
  - `vram_rd_addr` = `{v_cnt, h_cnt}` when active, else 20'h0.
- Stage 1: on `pix_ce`, register `active`, `hs_raw`, `vs_raw`, and an `origin` flag (`h_cnt==0 && v_cnt==0`).
- Stage 2 (outputs), on `pix_ce`:
  - RGB = `active_d1 ? vram_rd_data : 8'h00`
  - `blank` = `!active_d1`
  - `hsync` = `hs_d1 ? SYNC_POL : !SYNC_POL`; `vsync` likewise
  - `frame_start` = `origin_d1` for exactly one clk; 0 on every other clk, including non-`pix_ce` clks.
- Outside the active area, `vram_rd_data` is ignored entirely and never reaches the pins.
- No backpressure: VRAM must answer every read. A read collision with the GPU write port is resolved inside VRAM, not here.

## Timing
- Reset values: `h_cnt`=0, `v_cnt`=0, all pipeline flags 0, RGB=0, `blank`=1, `hsync`=`vsync`=`!SYNC_POL`, `vram_rd_en`=0, `frame_start`=0.
- Pixel latency: 2 `pix_ce` ticks from address issue to pins. Sync and blank carry the identical delay, so the pixel/sync phase relationship equals the counter relationship.
- `pix_ce` low:
  - All registers hold and `vram_rd_en` = 0.
  - Any `pix_ce` duty cycle is legal, including 1 (`pix_ce` tied high) and 1/4 (25 MHz from 100 MHz).
- Line wrap and frame wrap occur on the same `pix_ce` tick; no dead cycle.
- Reset asserted mid-frame: outputs take reset values immediately (asynchronously). After release, the first `pix_ce` restarts at (0,0), and `frame_start` fires on the 2nd `pix_ce` after release.

## Structure
- `vga_pkg` holds:
  - default timing localparams (640x480@60 set)
  - derived `H_TOTAL`/`V_TOTAL` and sync start/end constants
  - `typedef struct packed {logic [2:0] r; logic [2:0] g; logic [1:0] b;} rgb332_t`
  - a `pix_addr_t` 20-bit address typedef shared with the GPU controller
- Sub-module `vga_timing`: counters plus `active`/`hs_raw`/`vs_raw`/`origin` generation. `vga_scanout` adds the VRAM port and the 2-stage alignment pipeline.

## Test plan
- Reset: hold `rst_n`=0 with `pix_ce` toggling -> `blank`=1, `hsync`=`vsync`=1, RGB=0, `vram_rd_en`=0 throughout.
- First line, `pix_ce`=1 always, VRAM model returns `addr[7:0]`:
  - Tick 0 reads address 0; tick 639 reads 0x0027F.
  - `vga_r/g/b` show 0x00 at tick 2 and 0x7F at tick 641.
  - `blank` rises at tick 642.
- Sync:
  - `hsync` low for exactly 96 ticks starting at output tick 658.
  - `vsync` low for 1600 ticks (2 lines) starting at line 490 plus the 2-tick offset.
  - Successive `frame_start` pulses are exactly 420000 ticks apart.
- Blanking leak: VRAM model drives 0xFF constantly -> RGB=0 for all h≥640 or v≥480; `vram_rd_en` never high there.
- `pix_ce` 1-in-4, with VRAM data changing on idle clks after the valid cycle -> pin data matches the 1-clk-after-read value; the frame period is 1680000 clks.
- Reset at (h=300, v=200), held 3 clks -> outputs return to reset values within the same clk; `frame_start` occurs at the 2nd `pix_ce` after release.
